// File: rtl/lib_cpu.sv
// Shared CPU-side types and constants for the character-I/O path.
package lib_cpu;

   localparam int unsigned UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } TX_STATE;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous byte FIFO buffering UART receive data for the CPU.
module io_rx_fifo
   import lib_cpu::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [UART_BYTE_W-1:0] din,
   input  logic                   pop,
   output logic [UART_BYTE_W-1:0] dout,
   output logic [AW:0]            count,
   output logic                   full,
   output logic                   empty,
   output logic                   overrun_set
);

   logic [UART_BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]          wr_q, wr_d;
   logic [AW-1:0]          rd_q, rd_d;
   logic [AW:0]            count_q, count_d;
   logic                   do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_q];

   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign do_pop      = pop && !empty;
   assign do_push     = push && (!full || do_pop);
   assign overrun_set = push && full && !pop;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) begin
         wr_d = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din;
      end
   end

endmodule

// File: rtl/cpu_io_ctrl.sv
// CPU character-I/O sequencer: TX handshake FSM, RX byte FIFO and interrupt request.
module cpu_io_ctrl
   import lib_cpu::*;
#(
   parameter int unsigned RX_DEPTH = 4,
   localparam int unsigned RX_AW   = $clog2(RX_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_tx_req,
   input  logic [UART_BYTE_W-1:0] cpu_tx_data,
   input  logic                   cpu_ack,
   input  logic                   cpu_intr_en,
   output logic                   cpu_tx_busy,
   output logic [UART_BYTE_W-1:0] cpu_rx_data,
   output logic                   cpu_irr,
   output logic [RX_AW:0]         rx_count,
   output logic                   rx_overrun,
   output logic                   uart_tx_start,
   output logic [UART_BYTE_W-1:0] uart_tx_data,
   input  logic                   uart_tx_busy,
   input  logic                   uart_rx_valid,
   input  logic [UART_BYTE_W-1:0] uart_rx_data
);

   TX_STATE                state_q, state_d;
   logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
   logic                   tx_busy_q;
   logic                   irr_q, irr_d;
   logic                   overrun_q, overrun_d;
   logic                   rx_full, rx_empty, rx_overrun_set;
   logic                   rx_pend_d, rx_drain;

   io_rx_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (uart_rx_valid),
      .din         (uart_rx_data),
      .pop         (cpu_ack),
      .dout        (cpu_rx_data),
      .count       (rx_count),
      .full        (rx_full),
      .empty       (rx_empty),
      .overrun_set (rx_overrun_set)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      case (state_q)
         IDLE: begin
            if (cpu_tx_req) begin
               tx_data_d = cpu_tx_data;
               state_d   = START;
            end
         end
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: if (uart_tx_busy) state_d = WAIT_DONE;
         WAIT_DONE: if (!uart_tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FIFO is non-empty after this edge: a push always lands when not full, and
   // only a lone pop of the last byte empties it.
   always_comb begin
      rx_drain  = cpu_ack && !uart_rx_valid && (rx_count == (RX_AW+1)'(1));
      rx_pend_d = uart_rx_valid || rx_full || (!rx_empty && !rx_drain);
      irr_d     = cpu_intr_en && rx_pend_d;
      overrun_d = overrun_q;
      if (rx_overrun_set) begin
         overrun_d = 1'b1;
      end else if (rx_drain) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
         tx_busy_q <= 1'b0;
         irr_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         tx_busy_q <= (state_d != IDLE);
         irr_q     <= irr_d;
         overrun_q <= overrun_d;
      end
   end

   assign uart_tx_start = (state_q == START);
   assign uart_tx_data  = tx_data_q;
   assign cpu_tx_busy   = tx_busy_q;
   assign cpu_irr       = irr_q;
   assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Scoreboard bench for cpu_io_ctrl: stimulus queues expectations, monitors compare at negedge.
module tb_cpu_io_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_tx_req;
   logic [7:0] cpu_tx_data;
   logic       cpu_ack;
   logic       cpu_intr_en;
   logic       cpu_tx_busy;
   logic [7:0] cpu_rx_data;
   logic       cpu_irr;
   logic [2:0] rx_count;
   logic       rx_overrun;
   logic       uart_tx_start;
   logic [7:0] uart_tx_data;
   logic       uart_tx_busy;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      int         cnt;
      logic [7:0] data;
      logic       irr;
      logic       ovr;
      logic       busy;
      logic [7:0] txd;
   } exp_t;

   exp_t       chk_q[$];
   logic [7:0] tx_exp_q[$];

   always #5 clk = ~clk;

   cpu_io_ctrl #(
      .RX_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_tx_req    (cpu_tx_req),
      .cpu_tx_data   (cpu_tx_data),
      .cpu_ack       (cpu_ack),
      .cpu_intr_en   (cpu_intr_en),
      .cpu_tx_busy   (cpu_tx_busy),
      .cpu_rx_data   (cpu_rx_data),
      .cpu_irr       (cpu_irr),
      .rx_count      (rx_count),
      .rx_overrun    (rx_overrun),
      .uart_tx_start (uart_tx_start),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_busy  (uart_tx_busy),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data)
   );

   function automatic void cmp(string name, string field, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
      end
   endfunction

   // State monitor: every queued expectation is checked at the next falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            cmp(e.name, "rx_count", int'(rx_count), e.cnt);
            cmp(e.name, "rx_data", int'(cpu_rx_data), int'(e.data));
            cmp(e.name, "irr", int'(cpu_irr), int'(e.irr));
            cmp(e.name, "overrun", int'(rx_overrun), int'(e.ovr));
            cmp(e.name, "tx_busy", int'(cpu_tx_busy), int'(e.busy));
            cmp(e.name, "tx_data", int'(uart_tx_data), int'(e.txd));
         end
      end
   end

   // TX monitor: each start strobe must match one expected byte, in order.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (uart_tx_start === 1'b1) begin
            if (tx_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_start unexpected strobe data=%0h expected=none", uart_tx_data);
            end else begin
               b = tx_exp_q.pop_front();
               cmp("tx_start", "data", int'(uart_tx_data), int'(b));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      cpu_tx_req    = 1'b0;
      cpu_ack       = 1'b0;
      uart_rx_valid = 1'b0;
   endtask

   task automatic expect_st(string name, int cnt, logic [7:0] data, logic irr, logic ovr,
                            logic busy, logic [7:0] txd);
      exp_t e;
      e.name = name; e.cnt = cnt; e.data = data; e.irr = irr;
      e.ovr = ovr; e.busy = busy; e.txd = txd;
      chk_q.push_back(e);
   endtask

   task automatic rx_push(logic [7:0] b, logic ack);
      uart_rx_valid = 1'b1;
      uart_rx_data  = b;
      cpu_ack       = ack;
      cyc();
   endtask

   task automatic ack_once();
      cpu_ack = 1'b1;
      cyc();
   endtask

   initial begin
      rst = 1'b1; cpu_tx_req = 1'b0; cpu_tx_data = '0; cpu_ack = 1'b0;
      cpu_intr_en = 1'b0; uart_tx_busy = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
      cyc();
      expect_st("reset", 0, 8'h00, 0, 0, 0, 8'h00);
      rst = 1'b0;
      cyc();

      // TX handshake
      cpu_tx_req = 1'b1; cpu_tx_data = 8'h41; tx_exp_q.push_back(8'h41);
      cyc();
      expect_st("tx_start", 0, 8'h00, 0, 0, 1, 8'h41);
      cyc();
      expect_st("tx_wait_busy", 0, 8'h00, 0, 0, 1, 8'h41);
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            cpu_tx_req = 1'b1; cpu_tx_data = 8'h42;
         end
         cyc();
      end
      expect_st("tx_collision", 0, 8'h00, 0, 0, 1, 8'h41);
      // Request coincident with the return to IDLE must be dropped.
      uart_tx_busy = 1'b0; cpu_tx_req = 1'b1; cpu_tx_data = 8'h43;
      cyc();
      expect_st("tx_done", 0, 8'h00, 0, 0, 0, 8'h41);
      cyc();
      expect_st("tx_req_at_idle_entry", 0, 8'h00, 0, 0, 0, 8'h41);

      // RX FIFO with interrupts enabled
      cpu_intr_en = 1'b1;
      rx_push(8'h10, 0);
      expect_st("rx_first", 1, 8'h10, 1, 0, 0, 8'h41);
      rx_push(8'h11, 0);
      rx_push(8'h12, 0);
      expect_st("rx_three", 3, 8'h10, 1, 0, 0, 8'h41);
      ack_once(); expect_st("rx_pop1", 2, 8'h11, 1, 0, 0, 8'h41);
      ack_once(); expect_st("rx_pop2", 1, 8'h12, 1, 0, 0, 8'h41);
      ack_once(); expect_st("rx_pop3", 0, 8'h00, 0, 0, 0, 8'h41);

      // Overrun
      rx_push(8'h20, 0); rx_push(8'h21, 0); rx_push(8'h22, 0); rx_push(8'h23, 0);
      expect_st("ovr_full", 4, 8'h20, 1, 0, 0, 8'h41);
      rx_push(8'h24, 0);
      expect_st("ovr_drop", 4, 8'h20, 1, 1, 0, 8'h41);
      rx_push(8'h25, 1);
      expect_st("ovr_push_pop_full", 4, 8'h21, 1, 1, 0, 8'h41);
      ack_once(); expect_st("ovr_drain1", 3, 8'h22, 1, 1, 0, 8'h41);
      ack_once(); expect_st("ovr_drain2", 2, 8'h23, 1, 1, 0, 8'h41);
      ack_once(); expect_st("ovr_drain3", 1, 8'h25, 1, 1, 0, 8'h41);
      ack_once(); expect_st("ovr_drained", 0, 8'h00, 0, 0, 0, 8'h41);

      // Empty-FIFO corner cases and interrupt gating
      ack_once(); expect_st("pop_empty", 0, 8'h00, 0, 0, 0, 8'h41);
      cpu_intr_en = 1'b0;
      rx_push(8'h30, 1);
      expect_st("push_pop_empty_gated", 1, 8'h30, 0, 0, 0, 8'h41);
      cpu_intr_en = 1'b1;
      cyc();
      expect_st("irr_enable", 1, 8'h30, 1, 0, 0, 8'h41);

      // Reset in WAIT_BUSY with two bytes queued
      rx_push(8'h31, 0);
      cpu_tx_req = 1'b1; cpu_tx_data = 8'h55; tx_exp_q.push_back(8'h55);
      cyc();
      cyc();
      expect_st("pre_reset", 2, 8'h30, 1, 0, 1, 8'h55);
      rst = 1'b1;
      cyc();
      expect_st("mid_reset", 0, 8'h00, 0, 0, 0, 8'h00);
      rst = 1'b0; uart_tx_busy = 1'b1;
      cyc();
      uart_tx_busy = 1'b0;
      cyc();
      expect_st("busy_fall_ignored", 0, 8'h00, 0, 0, 0, 8'h00);
      cpu_tx_req = 1'b1; cpu_tx_data = 8'h66; tx_exp_q.push_back(8'h66);
      cyc();
      expect_st("post_reset_tx", 0, 8'h00, 0, 0, 1, 8'h66);
      cyc();
      uart_tx_busy = 1'b1;
      cyc();
      uart_tx_busy = 1'b0;
      cyc();
      expect_st("post_reset_done", 0, 8'h00, 0, 0, 0, 8'h66);

      @(negedge clk);
      #1;
      checks++;
      if (tx_exp_q.size() != 0) begin
         errors++;
         $display("FAIL tx_missing pending=%0d expected=0", tx_exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
